// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Bits needed to hold values 0..v-1 (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: asserts immediately, releases on the
// second clock edge after the raw reset deasserts.
module rst_sync_2ff (
  input  logic clk_i,
  input  logic arst_ni,
  output logic srst_no
);

  logic meta_q;
  logic sync_q;

  // Shift a one in behind the asynchronous clear.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign srst_no = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// Ordered per-domain reset release with a soft-reset drain/re-release loop.
// Domain 0 comes out of reset first and goes back in last, so the released
// set is always a contiguous run from bit 0 (thermometer code).
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SOFT_RST_REQ,
  output logic                   SOFT_RST_ACK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   SEQ_DONE,
  output logic                   BUSY
);

  localparam int CNT_W = clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = max2(1, clog2(NUM_DOMAINS));

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_DRAIN0 = IDX_W'(max2(NUM_DOMAINS - 2, 0));

  logic rst_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [NUM_DOMAINS-1:0] dom_q,   dom_d;
  logic                   done_q,  done_d;
  logic                   busy_q,  busy_d;
  logic                   ack_q,   ack_d;

  rst_sync_2ff u_sync (
    .clk_i   (CLK),
    .arst_ni (RST),
    .srst_no (rst_s)
  );

  // Next-state: counter paces each step and is cleared whenever a domain
  // changes, so it never needs to wrap. Releases shift a one in at bit 0,
  // drains shift the top bit out, keeping the thermometer shape by design.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          dom_d = NUM_DOMAINS'({dom_q, 1'b1});
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          dom_d = NUM_DOMAINS'({dom_q, 1'b1});
          if (idx_q == IDX_TOP) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (SOFT_RST_REQ) begin
          ack_d  = 1'b1;
          done_d = 1'b0;
          busy_d = 1'b1;
          cnt_d  = '0;
          dom_d  = dom_q >> 1;
          if (NUM_DOMAINS == 1) begin
            state_d = ST_HOLD;
            idx_d   = '0;
          end else begin
            state_d = ST_DRAIN;
            idx_d   = IDX_DRAIN0;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          dom_d = dom_q >> 1;
          if (idx_q == '0) begin
            state_d = ST_HOLD;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // State and registered outputs, cleared by the synchronized reset.
  always_ff @(posedge CLK or negedge rst_s) begin
    if (!rst_s) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign DOMAIN_RST_N = dom_q;
  assign SEQ_DONE     = done_q;
  assign BUSY         = busy_q;
  assign SOFT_RST_ACK = ack_q;

  // A released domain always has every lower-indexed domain released too.
  a_thermo: assert property (@(posedge CLK)
    ((DOMAIN_RST_N >> 1) & ~DOMAIN_RST_N) == '0);

  // The acknowledge edge is also the edge that drops SEQ_DONE.
  a_ack_done: assert property (@(posedge CLK) !(SOFT_RST_ACK && SEQ_DONE));

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: an edge-timeline model for the 3-domain instance
// plus directed literal checks, and a 1-domain corner instance.
module tb_rst_sequencer;

  localparam int ND = 3;
  localparam int HC = 4;
  localparam int GC = 2;

  logic CLK   = 1'b0;
  logic RST   = 1'b0;
  logic REQ   = 1'b0;
  logic rst_b = 1'b0;
  logic req_b = 1'b0;

  logic          ack_a, done_a, busy_a;
  logic [ND-1:0] dom_a;
  logic          ack_b, done_b, busy_b;
  logic [0:0]    dom_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  rst_sequencer #(.NUM_DOMAINS(ND), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)) u_a (
    .CLK(CLK), .RST(RST), .SOFT_RST_REQ(REQ), .SOFT_RST_ACK(ack_a),
    .DOMAIN_RST_N(dom_a), .SEQ_DONE(done_a), .BUSY(busy_a)
  );

  rst_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_b (
    .CLK(CLK), .RST(rst_b), .SOFT_RST_REQ(req_b), .SOFT_RST_ACK(ack_b),
    .DOMAIN_RST_N(dom_b), .SEQ_DONE(done_b), .BUSY(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Model: outputs are a function of how many edges have passed since the
  // last power-on origin (synchronized reset release, or end of a drain) or
  // since the last accepted soft reset.
  int e = 0, sync = 0, ph = 0, eo = 0, ea = -100;
  bit pdone = 1'b0;
  always @(posedge CLK) begin
    logic          r, q, xdone, xack, xbusy;
    logic [ND-1:0] xd;
    int            k, c;
    r = RST;
    q = REQ;
    e++;
    if (!r) begin
      sync = 0;
      ph   = 0;
    end else if (sync < 2) begin
      sync++;
      if (sync == 2) begin ph = 1; eo = e; end
    end else if (ph == 1 && pdone && q) begin
      ph = 2;
      ea = e;
    end
    c = 0;
    if (ph == 2) begin
      c = ND - 1 - (e - ea) / GC;
      if (c <= 0) begin ph = 1; eo = e; end
    end
    if (ph == 1) begin
      k = e - eo;
      c = (k < HC) ? 0 : 1 + (k - HC) / GC;
      if (c > ND) c = ND;
    end
    if (ph == 0) c = 0;
    xd    = ND'((32'd1 << c) - 1);
    xdone = (ph == 1) && (c == ND);
    xbusy = !xdone;
    xack  = (e == ea);
    pdone = xdone;
    #1;
    chk("m_dom",  32'(dom_a),  32'(xd));
    chk("m_done", 32'(done_a), 32'(xdone));
    chk("m_busy", 32'(busy_a), 32'(xbusy));
    chk("m_ack",  32'(ack_a),  32'(xack));
    chk("b_ack_vs_done", 32'(ack_b & done_b), 32'd0);
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Power-on
    step(1);
    chk("rst_dom", 32'(dom_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    step(1); chk("po_rsts_e1", 32'(u_a.rst_s), 32'd0);
    step(1); chk("po_rsts_e2", 32'(u_a.rst_s), 32'd1);
    chk("po_dom_e2", 32'(dom_a), 32'd0);
    step(4); chk("po_dom_e6", 32'(dom_a), 32'b001);
    chk("po_busy_e6", 32'(busy_a), 32'd1);
    step(2); chk("po_dom_e8", 32'(dom_a), 32'b011);
    step(1); chk("po_done_e9", 32'(done_a), 32'd0);
    step(1); chk("po_dom_e10", 32'(dom_a), 32'b111);
    chk("po_done_e10", 32'(done_a), 32'd1);
    chk("po_busy_e10", 32'(busy_a), 32'd0);

    // Soft reset, single-cycle request
    step(3);
    @(negedge CLK); REQ = 1'b1;
    step(1); chk("sr_ack", 32'(ack_a), 32'd1);
    chk("sr_dom0", 32'(dom_a), 32'b011);
    chk("sr_done0", 32'(done_a), 32'd0);
    chk("sr_busy0", 32'(busy_a), 32'd1);
    @(negedge CLK); REQ = 1'b0;
    step(1); chk("sr_ack_drop", 32'(ack_a), 32'd0);
    step(1); chk("sr_dom2", 32'(dom_a), 32'b001);
    step(2); chk("sr_dom4", 32'(dom_a), 32'b000);
    step(4); chk("sr_dom8", 32'(dom_a), 32'b001);
    step(2); chk("sr_dom10", 32'(dom_a), 32'b011);
    step(2); chk("sr_dom12", 32'(dom_a), 32'b111);
    chk("sr_done12", 32'(done_a), 32'd1);

    // Request raised during RELEASE, held into RUN
    step(3);
    @(negedge CLK); REQ = 1'b1;
    step(1); chk("rq_ack0", 32'(ack_a), 32'd1);
    @(negedge CLK); REQ = 1'b0;
    step(8); chk("rq_dom8", 32'(dom_a), 32'b001);
    @(negedge CLK); REQ = 1'b1;
    step(1); chk("rq_ack9", 32'(ack_a), 32'd0);
    step(1); chk("rq_ack10", 32'(ack_a), 32'd0);
    chk("rq_dom10", 32'(dom_a), 32'b011);
    step(1); chk("rq_ack11", 32'(ack_a), 32'd0);
    step(1); chk("rq_ack12", 32'(ack_a), 32'd0);
    chk("rq_done12", 32'(done_a), 32'd1);
    step(1); chk("rq_ack13", 32'(ack_a), 32'd1);
    chk("rq_dom13", 32'(dom_a), 32'b011);
    chk("rq_done13", 32'(done_a), 32'd0);
    @(negedge CLK); REQ = 1'b0;

    // Mid-sequence reset while two domains are released
    step(10); chk("mr_pre_dom", 32'(dom_a), 32'b011);
    RST = 1'b0;
    #1;
    chk("mr_async_dom", 32'(dom_a), 32'd0);
    chk("mr_async_busy", 32'(busy_a), 32'd1);
    chk("mr_async_done", 32'(done_a), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    step(2); chk("mr_dom_e2", 32'(dom_a), 32'd0);
    step(4); chk("mr_dom_e6", 32'(dom_a), 32'b001);
    step(2); chk("mr_dom_e8", 32'(dom_a), 32'b011);
    step(2); chk("mr_dom_e10", 32'(dom_a), 32'b111);
    chk("mr_done_e10", 32'(done_a), 32'd1);

    // One-cycle reset glitch in RUN
    step(2);
    @(negedge CLK); RST = 1'b0;
    step(1); chk("gl_dom", 32'(dom_a), 32'd0);
    chk("gl_busy", 32'(busy_a), 32'd1);
    @(negedge CLK); RST = 1'b1;
    step(6); chk("gl_dom_e6", 32'(dom_a), 32'b001);
    step(2); chk("gl_dom_e8", 32'(dom_a), 32'b011);
    step(2); chk("gl_dom_e10", 32'(dom_a), 32'b111);
    chk("gl_busy_e10", 32'(busy_a), 32'd0);

    // Single-domain corner
    @(negedge CLK); rst_b = 1'b1;
    step(2); chk("c1_dom_e2", 32'(dom_b), 32'd0);
    chk("c1_busy_e2", 32'(busy_b), 32'd1);
    step(1); chk("c1_dom_e3", 32'(dom_b), 32'd1);
    chk("c1_done_e3", 32'(done_b), 32'd1);
    chk("c1_busy_e3", 32'(busy_b), 32'd0);
    step(2);
    @(negedge CLK); req_b = 1'b1;
    step(1); chk("c1_ack", 32'(ack_b), 32'd1);
    chk("c1_dom_ack", 32'(dom_b), 32'd0);
    chk("c1_done_ack", 32'(done_b), 32'd0);
    chk("c1_busy_ack", 32'(busy_b), 32'd1);
    @(negedge CLK); req_b = 1'b0;
    step(1); chk("c1_dom_rel", 32'(dom_b), 32'd1);
    chk("c1_done_rel", 32'(done_b), 32'd1);
    chk("c1_ack_rel", 32'(ack_b), 32'd0);
    step(1); chk("c1_ack_after", 32'(ack_b), 32'd0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Controller for the system reset path. It synchronizes the raw asynchronous reset internally with a 2-flop synchronizer, then releases per-domain resets in a fixed order with programmable hold and gap delays.
- Supports a software-requested reset with a req/ack handshake. On a soft reset, domains are re-asserted in reverse order, then the power-on sequence runs again.
- Sits at the top level between the board reset and the UART TX/RX, baud-generator and register-file blocks.

Parameters:
- NUM_DOMAINS, 3: number of sequenced reset outputs; index 0 is released first. Legal range 1..8.
- HOLD_CYCLES, 16: cycles all domains stay in reset after the synchronized reset releases. Must be >= 1.
- GAP_CYCLES, 8: cycles between consecutive domain releases or re-assertions. Must be >= 1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- SOFT_RST_REQ  input  1  level request for a software reset; sampled on CLK.
- SOFT_RST_ACK  output  1  one-cycle pulse when a soft reset is accepted.
- DOMAIN_RST_N  output  NUM_DOMAINS  per-domain active-low resets, registered.
- SEQ_DONE  output  1  high while all domains are released (RUN state).
- BUSY  output  1  high whenever the sequencer is not in RUN.

Behaviour:
- Reset: RST low asynchronously forces the following, regardless of the clock:
  - DOMAIN_RST_N = all 0
  - SEQ_DONE = 0, SOFT_RST_ACK = 0, BUSY = 1
  - state = HOLD, counter = 0, domain index = 0
- Internal sync:
  - RST feeds a 2-flop synchronizer: asynchronous assert, synchronous release.
  - rst_s rises on the 2nd CLK edge after RST deasserts.
  - All FSM flops use rst_s as their asynchronous clear.
- Counter width: CNT_W = clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1). The counter never wraps: it is cleared on every state or index change.
- FSM states: HOLD, RELEASE, RUN, DRAIN.
- HOLD:
  - Counter increments from 0.
  - DOMAIN_RST_N[0] goes high exactly HOLD_CYCLES edges after rst_s rises; the state then moves to RELEASE with index = 1.
  - If NUM_DOMAINS == 1, the state moves directly to RUN.
- RELEASE:
  - Every GAP_CYCLES edges, DOMAIN_RST_N[index] goes high and index increments.
  - The edge that releases domain NUM_DOMAINS-1 also sets SEQ_DONE = 1 and BUSY = 0, and moves the state to RUN.
  - Release is cumulative: once a bit is high it stays high until DRAIN or reset.
- RUN:
  - All outputs are steady.
  - SOFT_RST_REQ sampled high triggers, on the next edge:
    - SOFT_RST_ACK = 1 for exactly 1 cycle
    - SEQ_DONE = 0, BUSY = 1
    - DOMAIN_RST_N[NUM_DOMAINS-1] = 0
    - state = DRAIN, index = NUM_DOMAINS-2
- DRAIN:
  - Every GAP_CYCLES edges, DOMAIN_RST_N[index] goes low and index decrements.
  - The edge that clears bit 0 moves the state to HOLD with counter = 0; the normal release sequence then repeats.
  - If NUM_DOMAINS == 1, the state goes from RUN directly to HOLD.
- SOFT_RST_REQ outside RUN is ignored: it is neither latched nor acknowledged.
- Level semantics: if REQ is still high when RUN is re-entered, a new soft reset starts on the next edge. Requesters must drop REQ after seeing ACK.
- RST asserted mid-sequence (any state) aborts immediately to the reset values. There is no partial-state retention.
- Output invariant, checked by assertion: DOMAIN_RST_N is always thermometer-coded, i.e. bit k high implies bit k-1 high.
- SOFT_RST_ACK is never high in the same cycle as SEQ_DONE.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum (HOLD, RELEASE, RUN, DRAIN), 2-bit encoding
  - clog2 helper function
  - max helper used to derive CNT_W
- One sub-module, rst_sync_2ff: 2-flop reset synchronizer with asynchronous assert and synchronous release. It is instantiated once for rst_s.
- The FSM, counter and index logic stay in rst_sequencer.

Test Plan:
All scenarios use NUM_DOMAINS=3, HOLD_CYCLES=4, GAP_CYCLES=2.
- Power-on: RST low 5 cycles, then high.
  - rst_s rises at edge 2.
  - DOMAIN_RST_N: 001 at edge 6, 011 at edge 8, 111 at edge 10.
  - SEQ_DONE and BUSY toggle at edge 10.
- Soft reset: in RUN, pulse SOFT_RST_REQ for 1 cycle.
  - Next edge: ACK=1 for 1 cycle, DOMAIN_RST_N=011, SEQ_DONE=0.
  - +2 edges: 001. +4 edges: 000.
  - Then 001/011/111 again at +8, +10, +12.
- Request during sequence: hold SOFT_RST_REQ high through RELEASE.
  - No ACK before RUN.
  - ACK is asserted on the edge after RUN is entered.
  - A second full cycle follows.
- Mid-sequence reset: assert RST while DOMAIN_RST_N=011.
  - Outputs go to 000 asynchronously, with no CLK edge needed; BUSY=1.
  - Release restarts the full power-on timing.
- Glitch: 1-cycle RST low pulse in RUN.
  - All domains reset.
  - Full sequence repeats with the power-on timing.
- Parameter corner: NUM_DOMAINS=1, HOLD=1, GAP=1.
  - Release 1 edge after rst_s.
  - Soft reset drops the output on the ACK edge and re-releases 1 edge later.
